// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory,
// holds one fetched instruction for decode, and handles redirects from
// downstream (branches/jumps), discarding data from squashed requests.
//
// Handshakes:
//   imem_req/imem_ack : a request is outstanding while imem_req=1. imem_addr
//     is held stable until the cycle imem_ack=1, which completes it and
//     carries imem_rdata in that same cycle.
//   instr_valid/instr_ready : the held instruction transfers on a cycle where
//     instr_valid=1 and instr_ready=1. While instr_valid=1 and not accepted,
//     instr/instr_pc/opcode/pc_plus4 stay stable. A redirect withdraws the
//     held instruction, even if instr_ready is also high.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        VALID  = 2'd2,
        SQUASH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] target_aligned;
    logic        capture;
    logic        load_req;

    // Redirect targets are always forced onto a word boundary.
    assign target_aligned = {redirect_target[31:2], 2'b00};

    // Next-state, next-pc and capture decisions for the fetch FSM.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
                if (redirect) pc_next = target_aligned;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the old path: drop it and
                        // re-issue at the target next cycle.
                        pc_next = target_aligned;
                    end else begin
                        capture    = 1'b1;
                        pc_next    = req_addr + 32'd4;
                        state_next = VALID;
                    end
                end else if (redirect) begin
                    // Request cannot be abandoned; wait out its ack in SQUASH.
                    pc_next    = target_aligned;
                    state_next = SQUASH;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_next    = target_aligned;
                    state_next = REQ;
                end else if (instr_ready) begin
                    state_next = REQ;
                end
            end
            SQUASH: begin
                if (redirect) pc_next = target_aligned;
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // A new request address is latched whenever a fresh request begins,
    // including a re-issue from REQ after a same-cycle ack+redirect.
    assign load_req = (state_next == REQ) && ((state != REQ) || redirect);

    // State, PC, request address and held instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            instr    <= 32'd0;
            instr_pc <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_req) req_addr <= pc_next;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= req_addr;
            end
        end
    end

    assign imem_req    = (state == REQ) || (state == SQUASH);
    assign imem_addr   = req_addr;
    assign instr_valid = (state == VALID);
    assign opcode      = instr[31:26];
    assign pc_plus4    = instr_pc + 32'd4;
    assign fsm_state   = state;

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the byte address loaded into the PC on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL indicate an instruction-memory request is outstanding.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned request byte address; stable while imem_req=1 and imem_ack=0.
REQ-006 imem_ack  input  1  SHALL signal request completion; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-008 redirect  input  1  SHALL request a PC change (taken branch/jump from downstream).
REQ-009 redirect_target  input  32  SHALL be the new PC; sampled only when redirect=1.
REQ-010 instr_ready  input  1  SHALL indicate downstream decode accepts the held instruction.
REQ-011 instr_valid  output  1  SHALL indicate instr, instr_pc and opcode are valid.
REQ-012 instr  output  32  SHALL hold the fetched instruction word.
REQ-013 opcode  output  6  SHALL equal instr[31:26], feeding the main control unit.
REQ-014 instr_pc  output  32  SHALL hold the byte address of instr.
REQ-015 pc_plus4  output  32  SHALL equal instr_pc + 4 (mod 2^32).

Function
REQ-016 FSM states SHALL be IDLE, REQ, VALID, SQUASH.
REQ-017 IDLE: imem_req=0; next state REQ unconditionally; redirect in IDLE loads pc.
REQ-018 Entering REQ, req_addr SHALL be loaded from pc; imem_addr=req_addr; imem_req=1 throughout REQ and SQUASH.
REQ-019 REQ, ack=1, redirect=0: instr<=imem_rdata, instr_pc<=req_addr, pc<=req_addr+4, instr_valid<=1, go VALID.
REQ-020 REQ, ack=1, redirect=1: rdata discarded, pc<=target, stay REQ issuing new request at target next cycle.
REQ-021 REQ, ack=0, redirect=1: pc<=target, go SQUASH; imem_addr keeps old req_addr (request not abandoned).
REQ-022 SQUASH: on ack, rdata discarded, go REQ; redirect in SQUASH overwrites pc, latest target wins.
REQ-023 VALID: instr_valid=1, outputs held stable until accepted or redirected.
REQ-024 VALID, instr_ready=1, redirect=0: instr_valid<=0, go REQ.
REQ-025 VALID, redirect=1: redirect SHALL take priority over instr_ready; instr_valid<=0, pc<=target, go REQ.
REQ-026 redirect_target[1:0] SHALL be forced to 2'b00 on load; pc increment wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-027 With single-cycle ack and instr_ready tied high, throughput SHALL be one instruction per 2 cycles; first instr_valid 2 cycles after reset release.
REQ-028 instr_valid SHALL never assert for data returned by a request squashed by redirect.

Reset
REQ-029 On rst=1, immediately: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0; opcode=0, pc_plus4=4.
REQ-030 Reset mid-request SHALL drop imem_req; any later ack for that request SHALL be ignored (IDLE ignores imem_ack).

Verification
REQ-031 Reset, ack every request cycle with rdata=addr-derived words, instr_ready=1 -> instr_pc sequence 0,4,8,... each valid 1 cycle in 2; opcode=instr[31:26].
REQ-032 instr_ready=0 for 5 cycles in VALID -> instr, instr_pc stable, imem_req=0, no new fetch until ready.
REQ-033 Ack delayed 3 cycles, redirect to 32'h0000_0103 in first REQ cycle -> imem_addr stays 0 until ack, data discarded, next request addr 32'h0000_0100, instr_pc=0x100.
REQ-034 redirect and instr_ready both high in VALID -> held instr dropped, next instr_pc=target.
REQ-035 RESET_PC=32'hFFFF_FFFC -> fetches 0xFFFFFFFC then 0x00000000; pc_plus4 of first =0.
REQ-036 Assert rst while imem_req=1 and ack pending -> imem_req=0 same cycle, instr_valid=0; after release fetch restarts at RESET_PC.
